// File: rtl/placement_result_collector.sv
// Collects placement engine results PIPE_LAT cycles after each request and
// queues them, tagged with a request sequence number, in a first-word-fall-through buffer.
module placement_result_collector #(
   parameter int PIPE_LAT = 6,
   parameter int DEPTH    = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     issue_valid_i,
   input  logic [7:0]               index_x_i,
   input  logic [7:0]               index_y_i,
   input  logic [3:0]               strike_i,
   input  logic                     res_ready_i,
   output logic                     res_valid_o,
   output logic [7:0]               res_id_o,
   output logic [7:0]               res_x_o,
   output logic [7:0]               res_y_o,
   output logic [3:0]               res_strike_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [7:0] tag;
      logic [7:0] x;
      logic [7:0] y;
      logic [3:0] strike;
   } entry_t;

   logic [PIPE_LAT-1:0] vld_pipe;
   logic                cap;
   logic [7:0]          tag;
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   entry_t              mem [DEPTH];
   entry_t              head;
   logic                pop;
   logic                push_ok;
   logic                full;

   // The last delay stage lines up with the engine outputs for that request.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= issue_valid_i;
         for (int i = 1; i < PIPE_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
         end
      end
   end

   assign cap     = vld_pipe[PIPE_LAT-1];
   assign full    = (count_o == CW'(DEPTH));
   assign pop     = res_valid_o && res_ready_i;
   // A pop frees the head slot this same edge, so a full buffer can still accept.
   assign push_ok = cap && (!full || pop);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tag        <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_o    <= '0;
         overflow_o <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (cap) begin
            tag <= tag + 8'd1;
         end
         if (push_ok) begin
            mem[wr_ptr] <= '{tag: tag, x: index_x_i, y: index_y_i, strike: strike_i};
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (cap && !push_ok) begin
            overflow_o <= 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop})
            2'b10:   count_o <= count_o + CW'(1);
            2'b01:   count_o <= count_o - CW'(1);
            default: count_o <= count_o;
         endcase
      end
   end

   assign head         = mem[rd_ptr];
   assign res_valid_o  = (count_o != '0);
   assign res_id_o     = res_valid_o ? head.tag    : '0;
   assign res_x_o      = res_valid_o ? head.x      : '0;
   assign res_y_o      = res_valid_o ? head.y      : '0;
   assign res_strike_o = res_valid_o ? head.strike : '0;

endmodule

// File: tb/tb_placement_result_collector.sv
// Self-checking bench: randomized engine outputs and backpressure compared each
// cycle against a queue-based reference model, plus directed boundary scenarios.
module tb_placement_result_collector;

   localparam int PIPE_LAT = 6;
   localparam int DEPTH    = 8;
   localparam int CW       = $clog2(DEPTH) + 1;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          issue_valid_i = 1'b0;
   logic [7:0]    index_x_i = '0;
   logic [7:0]    index_y_i = '0;
   logic [3:0]    strike_i = '0;
   logic          res_ready_i = 1'b0;
   logic          res_valid_o;
   logic [7:0]    res_id_o;
   logic [7:0]    res_x_o;
   logic [7:0]    res_y_o;
   logic [3:0]    res_strike_o;
   logic [CW-1:0] count_o;
   logic          overflow_o;

   placement_result_collector #(.PIPE_LAT(PIPE_LAT), .DEPTH(DEPTH)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .issue_valid_i (issue_valid_i),
      .index_x_i     (index_x_i),
      .index_y_i     (index_y_i),
      .strike_i      (strike_i),
      .res_ready_i   (res_ready_i),
      .res_valid_o   (res_valid_o),
      .res_id_o      (res_id_o),
      .res_x_o       (res_x_o),
      .res_y_o       (res_y_o),
      .res_strike_o  (res_strike_o),
      .count_o       (count_o),
      .overflow_o    (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          iss_q[$];
   logic [27:0] mq[$];
   logic [7:0]  m_tag = '0;
   logic        m_ovf = 1'b0;
   logic        use_fixed = 1'b0;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, obs, exp, cyc);
      end
   endtask

   // One clock: drive inputs, advance the model, sample #1 after the edge, compare.
   task automatic cycle(input logic iss, input logic rdy, input logic rst);
      logic        cap;
      logic [27:0] e;
      cap = (iss_q.size() != 0) && (iss_q[0] == cyc - PIPE_LAT);
      issue_valid_i = iss;
      res_ready_i   = rdy;
      rst_i         = rst;
      if (cap && use_fixed) begin
         index_x_i = 8'h12;
         index_y_i = 8'h34;
         strike_i  = 4'd3;
      end else begin
         index_x_i = 8'($urandom);
         index_y_i = 8'($urandom);
         strike_i  = 4'($urandom);
      end
      if (rst) begin
         iss_q.delete();
         mq.delete();
         m_tag = '0;
         m_ovf = 1'b0;
      end else begin
         if (cap) void'(iss_q.pop_front());
         if (mq.size() != 0 && rdy) void'(mq.pop_front());
         if (cap) begin
            if (mq.size() < DEPTH) mq.push_back({m_tag, index_x_i, index_y_i, strike_i});
            else m_ovf = 1'b1;
            m_tag = m_tag + 8'd1;
         end
         if (iss) iss_q.push_back(cyc);
      end
      cyc++;
      @(posedge clk_i);
      #1;
      e = (mq.size() != 0) ? mq[0] : 28'd0;
      chk("valid",    32'(res_valid_o),  32'(mq.size() != 0));
      chk("id",       32'(res_id_o),     32'(e[27:20]));
      chk("x",        32'(res_x_o),      32'(e[19:12]));
      chk("y",        32'(res_y_o),      32'(e[11:4]));
      chk("strike",   32'(res_strike_o), 32'(e[3:0]));
      chk("count",    32'(count_o),      32'(mq.size()));
      chk("overflow", 32'(overflow_o),   32'(m_ovf));
   endtask

   initial begin
      int   lat;
      int   issued;
      int   popped;
      logic [7:0] exp_id;

      // Reset state
      cycle(1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      chk("rst_valid", 32'(res_valid_o), 32'd0);
      chk("rst_count", 32'(count_o), 32'd0);
      chk("rst_ovf",   32'(overflow_o), 32'd0);

      // Single request with known engine values and latency
      use_fixed = 1'b1;
      cycle(1'b1, 1'b0, 1'b0);
      lat = 1;
      while (!res_valid_o && lat < 20) begin
         cycle(1'b0, 1'b0, 1'b0);
         lat++;
      end
      chk("latency", 32'(lat), 32'(PIPE_LAT + 1));
      chk("single_id", 32'(res_id_o), 32'd0);
      chk("single_x", 32'(res_x_o), 32'h12);
      chk("single_y", 32'(res_y_o), 32'h34);
      chk("single_strike", 32'(res_strike_o), 32'd3);
      cycle(1'b0, 1'b1, 1'b0);
      chk("single_drained", 32'(count_o), 32'd0);
      use_fixed = 1'b0;

      // Burst of 10 with no ready: overflow, ids 0..7 retained, next id 10
      cycle(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < PIPE_LAT + 4; i++) cycle(1'b0, 1'b0, 1'b0);
      chk("burst_count", 32'(count_o), 32'(DEPTH));
      chk("burst_ovf", 32'(overflow_o), 32'd1);
      for (int k = 0; k < DEPTH; k++) begin
         chk("burst_id", 32'(res_id_o), 32'(k));
         cycle(1'b0, 1'b1, 1'b0);
      end
      chk("burst_empty", 32'(count_o), 32'd0);
      cycle(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < PIPE_LAT; i++) cycle(1'b0, 1'b0, 1'b0);
      chk("burst_next_id", 32'(res_id_o), 32'd10);
      chk("burst_ovf_sticky", 32'(overflow_o), 32'd1);

      // Full buffer with simultaneous pop and push: no drop
      cycle(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 2 * DEPTH + PIPE_LAT + 4; i++) begin
         cycle(i < 2 * DEPTH, i >= PIPE_LAT + DEPTH, 1'b0);
         if (i >= PIPE_LAT + DEPTH && i < PIPE_LAT + 2 * DEPTH)
            chk("full_cnt", 32'(count_o), 32'(DEPTH));
      end
      chk("full_no_ovf", 32'(overflow_o), 32'd0);

      // Tag wrap over 260 requests with ready held
      cycle(1'b0, 1'b0, 1'b1);
      exp_id = '0;
      popped = 0;
      for (int i = 0; i < 260 + PIPE_LAT + 3; i++) begin
         if (res_valid_o) begin
            chk("wrap_id", 32'(res_id_o), 32'(exp_id));
            exp_id = exp_id + 8'd1;
            popped++;
         end
         cycle(i < 260, 1'b1, 1'b0);
      end
      chk("wrap_total", 32'(popped), 32'd260);

      // Reset with requests in flight
      cycle(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < PIPE_LAT + 6; i++) begin
         cycle(1'b0, 1'b0, 1'b0);
         chk("no_ghost", 32'(res_valid_o), 32'd0);
      end
      cycle(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < PIPE_LAT; i++) cycle(1'b0, 1'b0, 1'b0);
      chk("post_rst_id", 32'(res_id_o), 32'd0);
      chk("post_rst_count", 32'(count_o), 32'd1);

      // Random issue and backpressure
      cycle(1'b0, 1'b0, 1'b1);
      issued = 0;
      while (issued < 50) begin
         logic iss;
         iss = 1'($urandom_range(0, 1));
         if (iss) issued++;
         cycle(iss, 1'($urandom_range(0, 1)), 1'b0);
      end
      for (int i = 0; i < PIPE_LAT + DEPTH + 4; i++) cycle(1'b0, 1'($urandom_range(0, 3) != 0), 1'b0);
      for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 1'b1, 1'b0);
      chk("rand_drained", 32'(count_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
